// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared constants for the I2C domain arbiter
// Purpose: FSM state encodings, domain labels, timer width and the
//          round-robin winner helper used by i2c_domain_arbiter.
// Ports:   none (package).
package i2c_arb_pkg;

  localparam int CNT_W = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GAP   = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam logic DOMAIN_D1 = 1'b0;
  localparam logic DOMAIN_D2 = 1'b1;

  // Only meaningful when at least one request is present.
  function automatic logic pick_winner(input logic d1_req, input logic d2_req,
                                       input logic last_served);
    if (d1_req && d2_req) return ~last_served;
    else if (d2_req)      return DOMAIN_D2;
    else                  return DOMAIN_D1;
  endfunction

endpackage

// File: rtl/i2c_arb_timer.sv
// rtl/i2c_arb_timer.sv - loadable down-counter with clear and expiry flag
// Purpose: counts the domain-switch quiet gap and the WAIT timeout; the two
//          phases never overlap so one counter serves both.
// Ports:   clk, rst (async active-high), clr (force to 0), load/load_val
//          (preset), expired (count is zero).
module i2c_arb_timer
  import i2c_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                count_d = '0;
    else if (load)          count_d = load_val;
    else if (count_q != '0) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // A load of N-1 makes expiry land on the N-th cycle after the load edge.
  assign expired = (count_q == '0);

endmodule

// File: rtl/i2c_domain_arbiter.sv
// rtl/i2c_domain_arbiter.sv - round-robin two-domain arbiter for the I2C master
// Purpose: shares i2c_sys_top between D1 and D2, labels the datapath with
//          domain_i2c, holds a quiet gap before a domain switch, isolates read
//          data per domain and (with I2C_ARB_TIMEOUT_EN) aborts hung reads.
// Ports:   dN_req/dN_addr in, dN_gnt/dN_rd_data/dN_valid/dN_err out;
//          sys_start/sys_slave_addr out, sys_done/sys_rd_data in;
//          domain_i2c, busy out. All outputs registered.
// Macro:   I2C_ARB_TIMEOUT_EN enables the WAIT timeout and dN_err strobes.
module i2c_domain_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SWITCH_GAP     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d1_req,
  input  logic [6:0] d1_addr,
  input  logic       d2_req,
  input  logic [6:0] d2_addr,
  output logic       d1_gnt,
  output logic       d2_gnt,
  output logic [7:0] d1_rd_data,
  output logic [7:0] d2_rd_data,
  output logic       d1_valid,
  output logic       d2_valid,
  output logic       d1_err,
  output logic       d2_err,
  output logic       domain_i2c,
  output logic       sys_start,
  output logic [6:0] sys_slave_addr,
  input  logic       sys_done,
  input  logic [7:0] sys_rd_data,
  output logic       busy
);

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(SWITCH_GAP - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic       winner_q, winner_d;
  logic       last_served_q, last_served_d;
  logic       domain_q, domain_d;
  logic [6:0] addr_q, addr_d;
  logic       sys_start_q, sys_start_d;
  logic       d1_gnt_q, d1_gnt_d, d2_gnt_q, d2_gnt_d;
  logic [7:0] d1_rd_data_q, d1_rd_data_d, d2_rd_data_q, d2_rd_data_d;
  logic       d1_valid_q, d1_valid_d, d2_valid_q, d2_valid_d;
  logic       d1_err_q, d1_err_d, d2_err_q, d2_err_d;
  logic       busy_q, busy_d;

  logic             win;
  logic             tmr_clr, tmr_load, tmr_expired;
  logic [CNT_W-1:0] tmr_load_val;

  assign win = pick_winner(d1_req, d2_req, last_served_q);

  i2c_arb_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    last_served_d = last_served_q;
    domain_d      = domain_q;
    addr_d        = addr_q;
    sys_start_d   = 1'b0;
    d1_rd_data_d  = d1_rd_data_q;
    d2_rd_data_d  = d2_rd_data_q;
    d1_valid_d    = 1'b0;
    d2_valid_d    = 1'b0;
    d1_err_d      = 1'b0;
    d2_err_d      = 1'b0;
    tmr_load      = 1'b0;
    tmr_load_val  = '0;

    case (state_q)
      ST_IDLE: begin
        if (d1_req || d2_req) begin
          winner_d      = win;
          last_served_d = win;
          addr_d        = (win == DOMAIN_D2) ? d2_addr : d1_addr;
          if (win != domain_q) begin
            state_d      = ST_GAP;
            tmr_load     = 1'b1;
            tmr_load_val = GAP_LOAD;
          end else begin
            state_d     = ST_START;
            sys_start_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        // The label only moves once the bus has been quiet for the full gap.
        if (tmr_expired) begin
          state_d     = ST_START;
          sys_start_d = 1'b1;
          domain_d    = winner_q;
        end
      end
      ST_START: begin
        state_d      = ST_WAIT;
        tmr_load     = 1'b1;
        tmr_load_val = TO_LOAD;
      end
      ST_WAIT: begin
        // Completion wins over a timeout landing in the same cycle.
        if (sys_done) begin
          state_d = ST_RESP;
          if (winner_q == DOMAIN_D2) begin
            d2_rd_data_d = sys_rd_data;
            d2_valid_d   = 1'b1;
          end else begin
            d1_rd_data_d = sys_rd_data;
            d1_valid_d   = 1'b1;
          end
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (tmr_expired) begin
          state_d  = ST_IDLE;
          d1_err_d = (winner_q == DOMAIN_D1);
          d2_err_d = (winner_q == DOMAIN_D2);
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    tmr_clr  = (state_d == ST_IDLE) && (state_q != ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
    d1_gnt_d = (state_d == ST_START || state_d == ST_WAIT || state_d == ST_RESP)
               && (winner_d == DOMAIN_D1);
    d2_gnt_d = (state_d == ST_START || state_d == ST_WAIT || state_d == ST_RESP)
               && (winner_d == DOMAIN_D2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      winner_q      <= DOMAIN_D1;
      last_served_q <= DOMAIN_D2;
      domain_q      <= DOMAIN_D1;
      addr_q        <= '0;
      sys_start_q   <= 1'b0;
      d1_gnt_q      <= 1'b0;
      d2_gnt_q      <= 1'b0;
      d1_rd_data_q  <= '0;
      d2_rd_data_q  <= '0;
      d1_valid_q    <= 1'b0;
      d2_valid_q    <= 1'b0;
      d1_err_q      <= 1'b0;
      d2_err_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      last_served_q <= last_served_d;
      domain_q      <= domain_d;
      addr_q        <= addr_d;
      sys_start_q   <= sys_start_d;
      d1_gnt_q      <= d1_gnt_d;
      d2_gnt_q      <= d2_gnt_d;
      d1_rd_data_q  <= d1_rd_data_d;
      d2_rd_data_q  <= d2_rd_data_d;
      d1_valid_q    <= d1_valid_d;
      d2_valid_q    <= d2_valid_d;
      d1_err_q      <= d1_err_d;
      d2_err_q      <= d2_err_d;
      busy_q        <= busy_d;
    end
  end

  assign d1_gnt         = d1_gnt_q;
  assign d2_gnt         = d2_gnt_q;
  assign d1_rd_data     = d1_rd_data_q;
  assign d2_rd_data     = d2_rd_data_q;
  assign d1_valid       = d1_valid_q;
  assign d2_valid       = d2_valid_q;
  assign d1_err         = d1_err_q;
  assign d2_err         = d2_err_q;
  assign domain_i2c     = domain_q;
  assign sys_start      = sys_start_q;
  assign sys_slave_addr = addr_q;
  assign busy           = busy_q;

endmodule

// File: doc/i2c_domain_arbiter.md
# i2c_domain_arbiter

Shares the single I2C master sequencer (`i2c_sys_top`) between two security-domain requesters, D1 and D2. It arbitrates read requests round-robin, drives the `domain_i2c` label, and enforces a quiet gap on the bus before any domain switch. It times out hung transactions and routes read data only to the requester that owns the transaction. It sits between the domain clients and `i2c_sys_top`, replacing the fixed two-read sequencer in the top level.

## Interface
- `TIMEOUT_CYCLES`, default 4096: maximum WAIT cycles before a transaction is aborted; 16-bit counter.
- `SWITCH_GAP`, default 16: idle cycles held before `domain_i2c` may change; must be ≥1.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `d1_req` / `d2_req` in 1: request level; held with address until `dN_valid` or `dN_err`.
- `d1_addr` / `d2_addr` in 7: target slave address.
- `d1_gnt` / `d2_gnt` out 1: owner indication, high START through RESP.
- `d1_rd_data` / `d2_rd_data` out 8: read result per domain.
- `d1_valid` / `d2_valid` out 1: one-cycle result strobe.
- `d1_err` / `d2_err` out 1: one-cycle timeout strobe.
- `domain_i2c` out 1: 0 = D1, 1 = D2; labels the master datapath.
- `sys_start` out 1: one-cycle start pulse to `i2c_sys_top`.
- `sys_slave_addr` out 7: address presented to `i2c_sys_top`.
- `sys_done` in 1: transaction-complete pulse.
- `sys_rd_data` in 8: read data from `i2c_sys_top`, valid with `sys_done`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States and transitions:
  - IDLE → GAP when the winner's domain differs from `domain_i2c`.
  - IDLE → START when the winner's domain equals `domain_i2c`.
  - GAP → START after `SWITCH_GAP` cycles.
  - START → WAIT, always.
  - WAIT → RESP on `sys_done`.
  - WAIT → IDLE on timeout.
  - RESP → IDLE, always.
- Arbitration in IDLE only:
  - Single request: that requester wins.
  - Both requesting: the domain other than `last_served` wins.
  - `last_served` resets to D2, so D1 wins the first contention.
- On winning:
  - Latch the winner ID and its address into `sys_slave_addr`, stable until IDLE.
  - Set `last_served` to the winner.
- GAP:
  - `domain_i2c` keeps its old value throughout; `sys_start` stays 0.
  - `domain_i2c` takes the new value on entry to START.
- START: `sys_start` = 1 for exactly this one cycle.
- WAIT:
  - `sys_done` captures `sys_rd_data` into the winner's `dN_rd_data` only.
  - The other domain's `rd_data` is never written, which is the isolation rule.
- RESP: winner's `dN_valid` = 1 for one cycle.
- Timeout: the winner's `dN_err` = 1 for one cycle and `rd_data` is unchanged. `sys_done` arriving in the same cycle as the timeout takes precedence; the result is a normal RESP.
- `sys_done` outside WAIT is ignored.
- `dN_req` dropped mid-transaction is ignored; the transaction completes and still strobes valid or err.
- Reset mid-operation:
  - Immediately return to IDLE.
  - All outputs 0, `domain_i2c` = 0, counters 0, `last_served` = D2.

## Timing
- All outputs are registered.
- Request sampled in IDLE cycle N:
  - Same domain: `sys_start` in cycle N+1.
  - Domain switch: `sys_start` in cycle N+1+`SWITCH_GAP`.
- `sys_done` sampled in cycle M: `dN_valid` and new `dN_rd_data` in cycle M+1.
- Timeout: err strobe in the cycle after the `TIMEOUT_CYCLES`-th WAIT cycle.
- A minimum of 1 IDLE cycle separates transactions.
- Best-case same-domain throughput is 1 transaction per (done latency + 3) cycles.

## Configuration
- Macro: `I2C_ARB_TIMEOUT_EN`.
- Defined: timeout counter and `dN_err` are built as described.
- Undefined:
  - WAIT exits only on `sys_done`.
  - `d1_err` and `d2_err` are tied 0.
  - `TIMEOUT_CYCLES` is unused.

## Structure
- Package `i2c_arb_pkg`:
  - State encodings (3-bit).
  - `DOMAIN_D1` = 1'b0 and `DOMAIN_D2` = 1'b1.
  - Counter width constant (16).
- Sub-module `i2c_arb_timer`:
  - Loadable down-counter with clear and an expiry flag.
  - Shared by GAP and WAIT, which are never concurrent.

## Test plan
- D1 only, addr 0x10, `sys_done` after 50 cycles with data 0x12:
  - `sys_start` 1 cycle after req, `sys_slave_addr` = 0x10.
  - `d1_valid` and `d1_rd_data` = 0x12 one cycle after done.
  - `d2_rd_data` remains 0x00.
- D1 then D2 requests simultaneously, with D2 addr 0x20 and data 0x90:
  - D1 is served first.
  - D2 `sys_start` exactly `SWITCH_GAP` + 1 cycles after IDLE.
  - `domain_i2c` flips on entry to START.
  - `d2_rd_data` = 0x90 and `d1_rd_data` is unchanged.
- Both requests held continuously: grants alternate D1, D2, D1, D2 across 4 transactions.
- `sys_done` withheld, macro defined, `TIMEOUT_CYCLES` = 100:
  - `d1_err` pulses after 100 WAIT cycles and the FSM returns to IDLE.
  - Same case with `sys_done` in the timeout cycle gives `d1_valid`, not err.
- `rst` asserted in WAIT:
  - Outputs 0 immediately; `busy` = 0.
  - A later `sys_done` produces no valid strobe.
  - The next contention grants D1.
